// File: rtl/idelay_scan_ctrl.sv
// idelay_scan_ctrl
//   Initiator side of the IDELAY delay_target/delay_ready handshake. On a start
//   request it sweeps delay_target across 0..TAP_MAX in SCAN_STEP increments. Each
//   point waits for delay_ready, settles, then dwells while collecting pattern
//   checker errors. The controller tracks the widest contiguous error-free window
//   and finally parks delay_target at that window's centre.
//
// Ports
//   clk160       in   fabric clock
//   rstb         in   asynchronous active-low reset
//   scan_start   in   1-cycle start request, ignored unless idle
//   delay_ready  in   IDELAY tap has reached delay_target
//   err_valid    in   qualifier for bit_err
//   bit_err      in   pattern mismatch this cycle
//   delay_target out  requested IDELAY tap (9 bits)
//   scan_busy    out  scan in progress
//   scan_done    out  1-cycle pulse at scan end
//   scan_fail    out  no passing point or handshake timeout (sticky until next start)
//   best_start   out  first tap of widest passing window (9 bits)
//   best_width   out  scan points in that window, 0 = none (7 bits)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for scan_start
// S_SET      | drive delay_target with the current scan tap
// S_WAIT_RDY | wait for delay_ready (bounded by TIMEOUT)
// S_SETTLE   | SETTLE_CYC cycles, errors ignored
// S_DWELL    | 2**DWELL_LOG2 cycles accumulating qualified errors
// S_EVAL     | update run/best window, advance tap
// S_CENTER   | drive delay_target to the centre of the best window
// S_WAIT_FIN | wait for delay_ready on the final target (bounded by TIMEOUT)
// S_DONE     | scan_done pulse, back to idle

module idelay_scan_ctrl #(
  parameter int TAP_MAX    = 511,
  parameter int SCAN_STEP  = 8,
  parameter int SETTLE_CYC = 8,
  parameter int DWELL_LOG2 = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk160,
  input  logic       rstb,
  input  logic       scan_start,
  input  logic       delay_ready,
  input  logic       err_valid,
  input  logic       bit_err,
  output logic [8:0] delay_target,
  output logic       scan_busy,
  output logic       scan_done,
  output logic       scan_fail,
  output logic [8:0] best_start,
  output logic [6:0] best_width
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int STL_W = $clog2(SETTLE_CYC + 1);
  localparam int DW_W  = DWELL_LOG2 + 1;

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
  localparam logic [STL_W-1:0] STL_LOAD = STL_W'(SETTLE_CYC - 1);
  localparam logic [DW_W-1:0]  DW_LOAD  = DW_W'((1 << DWELL_LOG2) - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SET, S_WAIT_RDY, S_SETTLE, S_DWELL, S_EVAL, S_CENTER, S_WAIT_FIN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       tap_q, tap_d;
  logic [8:0]       run_start_q, run_start_d;
  logic [6:0]       run_len_q, run_len_d;
  logic [8:0]       best_start_q, best_start_d;
  logic [6:0]       best_width_q, best_width_d;
  logic [8:0]       delay_target_q, delay_target_d;
  logic             scan_busy_q, scan_busy_d;
  logic             scan_done_q, scan_done_d;
  logic             scan_fail_q, scan_fail_d;
  logic             tap_err_q, tap_err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [STL_W-1:0] stl_q, stl_d;
  logic [DW_W-1:0]  dw_q, dw_d;

  // EVAL / CENTER helpers
  logic [9:0] tap_next;
  logic [6:0] run_len_inc;
  logic [8:0] run_start_new;
  logic [8:0] ctr_off;

  always_comb begin
    tap_next      = tap_q + 10'(SCAN_STEP);
    run_len_inc   = run_len_q + 7'd1;
    run_start_new = (run_len_q == 7'd0) ? tap_q[8:0] : run_start_q;
    // Offset of the window centre from its first tap, truncated toward the start.
    ctr_off       = 9'(((16'(best_width_q) - 16'd1) * 16'(SCAN_STEP)) >> 1);

    state_d        = state_q;
    tap_d          = tap_q;
    run_start_d    = run_start_q;
    run_len_d      = run_len_q;
    best_start_d   = best_start_q;
    best_width_d   = best_width_q;
    delay_target_d = delay_target_q;
    scan_busy_d    = scan_busy_q;
    scan_done_d    = 1'b0;
    scan_fail_d    = scan_fail_q;
    tap_err_d      = tap_err_q;
    tmo_d          = tmo_q;
    stl_d          = stl_q;
    dw_d           = dw_q;

    case (state_q)
      S_IDLE: begin
        if (scan_start) begin
          tap_d        = '0;
          run_start_d  = '0;
          run_len_d    = '0;
          best_start_d = '0;
          best_width_d = '0;
          scan_fail_d  = 1'b0;
          scan_busy_d  = 1'b1;
          state_d      = S_SET;
        end
      end
      S_SET: begin
        delay_target_d = tap_q[8:0];
        tap_err_d      = 1'b0;
        tmo_d          = TMO_LOAD;
        state_d        = S_WAIT_RDY;
      end
      S_WAIT_RDY, S_WAIT_FIN: begin
        if (delay_ready) begin
          if (state_q == S_WAIT_RDY) begin
            stl_d   = STL_LOAD;
            state_d = S_SETTLE;
          end else begin
            scan_busy_d = 1'b0;
            scan_done_d = 1'b1;
            state_d     = S_DONE;
          end
        end else if (tmo_q == '0) begin
          scan_fail_d = 1'b1;
          scan_busy_d = 1'b0;
          scan_done_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (stl_q == '0) begin
          dw_d    = DW_LOAD;
          state_d = S_DWELL;
        end else begin
          stl_d = stl_q - 1'b1;
        end
      end
      S_DWELL: begin
        tap_err_d = tap_err_q | (err_valid & bit_err);
        if (dw_q == '0) state_d = S_EVAL;
        else            dw_d    = dw_q - 1'b1;
      end
      S_EVAL: begin
        if (!tap_err_q) begin
          run_start_d = run_start_new;
          run_len_d   = run_len_inc;
          // Strict compare: on a tie the earlier window is kept.
          if (run_len_inc > best_width_q) begin
            best_start_d = run_start_new;
            best_width_d = run_len_inc;
          end
        end else begin
          run_len_d = '0;
        end
        tap_d   = tap_next;
        state_d = (tap_next > 10'(TAP_MAX)) ? S_CENTER : S_SET;
      end
      S_CENTER: begin
        if (best_width_q == 7'd0) begin
          scan_fail_d    = 1'b1;
          delay_target_d = '0;
        end else begin
          delay_target_d = best_start_q + ctr_off;
        end
        tmo_d   = TMO_LOAD;
        state_d = S_WAIT_FIN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      state_q        <= S_IDLE;
      tap_q          <= '0;
      run_start_q    <= '0;
      run_len_q      <= '0;
      best_start_q   <= '0;
      best_width_q   <= '0;
      delay_target_q <= '0;
      scan_busy_q    <= 1'b0;
      scan_done_q    <= 1'b0;
      scan_fail_q    <= 1'b0;
      tap_err_q      <= 1'b0;
      tmo_q          <= '0;
      stl_q          <= '0;
      dw_q           <= '0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      run_start_q    <= run_start_d;
      run_len_q      <= run_len_d;
      best_start_q   <= best_start_d;
      best_width_q   <= best_width_d;
      delay_target_q <= delay_target_d;
      scan_busy_q    <= scan_busy_d;
      scan_done_q    <= scan_done_d;
      scan_fail_q    <= scan_fail_d;
      tap_err_q      <= tap_err_d;
      tmo_q          <= tmo_d;
      stl_q          <= stl_d;
      dw_q           <= dw_d;
    end
  end

  assign delay_target = delay_target_q;
  assign scan_busy    = scan_busy_q;
  assign scan_done    = scan_done_q;
  assign scan_fail    = scan_fail_q;
  assign best_start   = best_start_q;
  assign best_width   = best_width_q;

endmodule

// File: tb/tb_idelay_scan_ctrl.sv
// tb_idelay_scan_ctrl
//   Directed bench for idelay_scan_ctrl. A short dwell keeps runs small; the
//   IDELAY is modelled as reaching the requested tap one cycle after it changes,
//   and bit_err is a function of the current delay_target per error profile.

module tb_idelay_scan_ctrl;

  logic       clk160 = 1'b0;
  logic       rstb;
  logic       scan_start;
  logic       delay_ready;
  logic       err_valid;
  logic       bit_err;
  logic [8:0] delay_target;
  logic       scan_busy;
  logic       scan_done;
  logic       scan_fail;
  logic [8:0] best_start;
  logic [6:0] best_width;

  int errors = 0;
  int checks = 0;

  logic [8:0] model_tap = '0;
  logic       rdy_en;
  logic       force_err;
  logic [1:0] err_mode;

  always #5 clk160 = ~clk160;

  idelay_scan_ctrl #(
    .TAP_MAX(511), .SCAN_STEP(8), .SETTLE_CYC(8), .DWELL_LOG2(3), .TIMEOUT(4096)
  ) dut (
    .clk160(clk160), .rstb(rstb), .scan_start(scan_start), .delay_ready(delay_ready),
    .err_valid(err_valid), .bit_err(bit_err), .delay_target(delay_target),
    .scan_busy(scan_busy), .scan_done(scan_done), .scan_fail(scan_fail),
    .best_start(best_start), .best_width(best_width)
  );

  always @(posedge clk160) model_tap <= delay_target;
  assign delay_ready = rdy_en && (model_tap == delay_target);

  // mode 1: fail below 100 and above 300; mode 2: pass only 0..48 and 200..248
  assign bit_err = force_err
                 | ((err_mode == 2'd1) && ((delay_target < 9'd100) || (delay_target > 9'd300)))
                 | ((err_mode == 2'd2) && !((delay_target <= 9'd48) ||
                                            ((delay_target >= 9'd200) && (delay_target <= 9'd248))));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input bit inject, output int busy_cyc, output bit got_done,
                          output bit fail0);
    busy_cyc = 0;
    got_done = 1'b0;
    @(negedge clk160); scan_start = 1'b1;
    @(negedge clk160); scan_start = 1'b0;
    fail0 = scan_fail;
    for (int n = 0; n < 20000 && !got_done; n++) begin
      if (scan_busy) busy_cyc++;
      if (scan_done) got_done = 1'b1;
      else begin
        scan_start = inject && (n == 50 || n == 400);
        @(negedge clk160);
      end
    end
    scan_start = 1'b0;
  endtask

  task automatic check_result(input string pfx, input int exp_start, input int exp_width,
                              input int exp_tgt, input int exp_fail);
    chk({pfx, "_best_start"}, 32'(best_start), 32'(exp_start));
    chk({pfx, "_best_width"}, 32'(best_width), 32'(exp_width));
    chk({pfx, "_target"},     32'(delay_target), 32'(exp_tgt));
    chk({pfx, "_fail"},       32'(scan_fail), 32'(exp_fail));
    chk({pfx, "_busy_at_done"}, 32'(scan_busy), 32'd0);
    @(negedge clk160);
    chk({pfx, "_done_1cyc"}, 32'(scan_done), 32'd0);
  endtask

  int bc;
  bit gd;
  bit f0;
  int pulses;

  initial begin
    rstb = 1'b0; scan_start = 1'b0; err_valid = 1'b1;
    rdy_en = 1'b1; force_err = 1'b0; err_mode = 2'd0;
    repeat (3) @(negedge clk160);
    chk("rst_target", 32'(delay_target), 32'd0);
    chk("rst_busy",   32'(scan_busy), 32'd0);
    chk("rst_done",   32'(scan_done), 32'd0);
    chk("rst_fail",   32'(scan_fail), 32'd0);
    chk("rst_bstart", 32'(best_start), 32'd0);
    chk("rst_bwidth", 32'(best_width), 32'd0);
    rstb = 1'b1;
    @(negedge clk160);

    // 1: clean sweep from reset; busy length = 19 + 63*20 + CENTER + 2 WAIT_FIN
    run_scan(1'b0, bc, gd, f0);
    chk("t1_done_seen", 32'(gd), 32'd1);
    chk("t1_busy_cycles", 32'(bc), 32'd1282);
    check_result("t1", 0, 64, 252, 0);

    // 2: window 104..296
    err_mode = 2'd1;
    run_scan(1'b0, bc, gd, f0);
    chk("t2_done_seen", 32'(gd), 32'd1);
    check_result("t2", 104, 25, 200, 0);

    // 3: two equal 7-point windows, earlier wins
    err_mode = 2'd2;
    run_scan(1'b0, bc, gd, f0);
    chk("t3_done_seen", 32'(gd), 32'd1);
    check_result("t3", 0, 7, 24, 0);

    // errors without err_valid are not counted
    err_mode = 2'd0; force_err = 1'b1; err_valid = 1'b0;
    run_scan(1'b0, bc, gd, f0);
    chk("qual_done_seen", 32'(gd), 32'd1);
    check_result("qual", 0, 64, 252, 0);

    // 4: every point fails
    err_valid = 1'b1;
    run_scan(1'b0, bc, gd, f0);
    chk("t4_done_seen", 32'(gd), 32'd1);
    check_result("t4", 0, 0, 0, 1);

    // 5: delay_ready stuck low; scan_fail clears on the accepted start
    force_err = 1'b0; rdy_en = 1'b0;
    run_scan(1'b0, bc, gd, f0);
    chk("t5_fail_cleared", 32'(f0), 32'd0);
    chk("t5_done_seen", 32'(gd), 32'd1);
    chk("t5_busy_cycles", 32'(bc), 32'd4097);
    check_result("t5", 0, 0, 0, 1);

    // 6: reset while dwelling on the second point
    rdy_en = 1'b1;
    @(negedge clk160); scan_start = 1'b1;
    @(negedge clk160); scan_start = 1'b0;
    begin
      int k;
      k = 0;
      while (delay_target == 9'd0 && k < 200) begin
        @(negedge clk160);
        k++;
      end
      chk("t6_reached_tap8", 32'(delay_target), 32'd8);
    end
    repeat (12) @(negedge clk160);
    #3 rstb = 1'b0;
    #1;
    chk("t6_rst_target", 32'(delay_target), 32'd0);
    chk("t6_rst_busy",   32'(scan_busy), 32'd0);
    chk("t6_rst_done",   32'(scan_done), 32'd0);
    chk("t6_rst_fail",   32'(scan_fail), 32'd0);
    chk("t6_rst_bstart", 32'(best_start), 32'd0);
    chk("t6_rst_bwidth", 32'(best_width), 32'd0);
    repeat (3) @(negedge clk160);
    rstb = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk160);
      if (scan_done || scan_busy) pulses++;
    end
    chk("t6_no_done_after_rst", 32'(pulses), 32'd0);

    // restarts while busy and in the DONE cycle are dropped
    err_mode = 2'd1;
    run_scan(1'b1, bc, gd, f0);
    chk("t6_done_seen", 32'(gd), 32'd1);
    chk("t6_bstart", 32'(best_start), 32'd104);
    chk("t6_bwidth", 32'(best_width), 32'd25);
    chk("t6_target", 32'(delay_target), 32'd200);
    scan_start = 1'b1;
    @(negedge clk160);
    scan_start = 1'b0;
    chk("t6_done_1cyc", 32'(scan_done), 32'd0);
    chk("t6_busy_after", 32'(scan_busy), 32'd0);
    @(negedge clk160);
    chk("t6_done_start_dropped", 32'(scan_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
